uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream, one byte per one-cycle `finished` pulse. It assembles ASCII frames of the form START_CHAR, N_DIGITS decimal digits, then END_CHAR. Each valid frame produces a packed BCD code and a one-cycle `frame_valid` pulse for the lock controller. Malformed, overlong or stalled frames are dropped and reported through `frame_error` and `error_code`.

Parameters:
N_DIGITS, 4, number of decimal digits per frame (1..8)
START_CHAR, 8'h23 ('#'), frame start byte
END_CHAR, 8'h0A ('\n'), frame terminator byte
TIMEOUT_CYCLES, 520_833, maximum clk cycles allowed between bytes inside a frame (about 10 byte times at 9600 baud, 50 MHz)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  parser enable; low forces IDLE
rx_data  input  8  received byte from the UART receiver
rx_valid  input  1  one-cycle strobe: rx_data is valid (receiver `finished`)
code  output  4*N_DIGITS  BCD code of the last valid frame; first digit in the MS nibble
frame_valid  output  1  one-cycle pulse: `code` updated
frame_error  output  1  one-cycle pulse: frame dropped
error_code  output  2  last error: 0 none, 1 BAD_CHAR, 2 TIMEOUT, 3 OVERLONG
busy  output  1  high while state != IDLE
digit_count  output  $clog2(N_DIGITS+1)  digits accepted in the current frame

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; code, digit_count, timeout counter, error_code = 0; frame_valid, frame_error, busy = 0.
- All outputs are registered. A pulse caused by a byte strobed in cycle t is high in cycle t+1 only.
- Digit test: rx_data in 8'h30..8'h39; nibble = rx_data - 8'h30.
- Internal shift buffer: on each accepted digit, buf <= {buf[4*N_DIGITS-5:0], nibble}. `code` is loaded from buf only on frame_valid.
- State IDLE:
  - START_CHAR: clear buf and digit_count, go to DIGITS.
  - Any other byte: ignored, no error.
- State DIGITS:
  - Digit: shift it in and increment digit_count. When the count reaches N_DIGITS, go to TERM.
  - START_CHAR: restart the frame (clear buf and count, stay in DIGITS), no error.
  - Any other byte: frame_error, error_code=1, go to IDLE.
- State TERM:
  - END_CHAR: code<=buf, frame_valid, error_code=0, go to IDLE.
  - 8'h0D ('\r'): ignored, counts as activity.
  - Digit: frame_error, error_code=3, go to IDLE.
  - START_CHAR: restart the frame and go to DIGITS.
  - Any other byte: error_code=1, go to IDLE.
- Timeout:
  - The counter clears on every rx_valid and on entry to IDLE, and increments while in DIGITS or TERM.
  - Reaching TIMEOUT_CYCLES-1 with no rx_valid: frame_error, error_code=2, go to IDLE.
  - If rx_valid coincides with the terminal count, rx_valid wins and no timeout fires.
  - The counter saturates; it never wraps.
- enable=0: synchronously go to IDLE and clear digit_count and the timeout counter. rx_valid is ignored, no pulses are generated, and code/error_code are retained.
- Returning to IDLE always clears digit_count. A dropped frame leaves `code` unchanged.
- error_code holds its value until the next error or a valid frame. frame_valid and frame_error are never high together.
- Reset asserted mid-frame: immediate IDLE with all outputs cleared. No pulse is emitted on reset release.
- rx_valid is assumed to be at most one cycle wide and never back-to-back. Back-to-back strobes are still processed one byte per cycle.

Test Plan:
- Valid frame: reset, then bytes "#1234\n" with 5208-cycle spacing -> frame_valid for 1 cycle after the '\n' strobe; code=16'h1234; error_code=0; busy low afterwards.
- Bad char: "#12a" -> frame_error one cycle after 'a'; error_code=1; code unchanged (16'h1234 from the previous test); digit_count=0.
- Overlong plus CR tolerance: "#98765\n" -> error_code=3 at '5'; then "#4321\r\n" -> frame_valid, code=16'h4321.
- Restart: "#12#5678\n" -> no error; single frame_valid; code=16'h5678.
- Timeout: "#12", then idle for TIMEOUT_CYCLES cycles -> frame_error exactly TIMEOUT_CYCLES-1 cycles after the '2' strobe (+1 register cycle); error_code=2. Repeat with a byte arriving on the terminal cycle -> no timeout.
- Reset/enable: assert reset mid-frame after "#12" -> outputs zero immediately; "34\n" afterwards -> no pulses. Drop enable during "#56" -> busy falls next cycle; no pulses.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_if
// Bundles the byte stream coming from the UART receiver together with the
// frame results presented to the lock controller.
//   enable       parser enable (low forces the parser idle)
//   rx_data      received byte
//   rx_valid     one-cycle strobe qualifying rx_data
//   code         BCD code of the last valid frame, first digit in MS nibble
//   frame_valid  one-cycle pulse, code updated
//   frame_error  one-cycle pulse, frame dropped
//   error_code   last error: 0 none, 1 bad char, 2 timeout, 3 overlong
//   busy         parser is inside a frame
//   digit_count  digits accepted in the current frame
// master: byte source / result consumer side. slave: the parser.
// ---------------------------------------------------------------------------
interface uart_frame_parser_if #(
  parameter int N_DIGITS = 4
);
  localparam int CW  = 4 * N_DIGITS;
  localparam int DCW = $clog2(N_DIGITS + 1);

  logic           enable;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [CW-1:0]  code;
  logic           frame_valid;
  logic           frame_error;
  logic [1:0]     error_code;
  logic           busy;
  logic [DCW-1:0] digit_count;

  modport master (
    output enable, rx_data, rx_valid,
    input  code, frame_valid, frame_error, error_code, busy, digit_count
  );

  modport slave (
    input  enable, rx_data, rx_valid,
    output code, frame_valid, frame_error, error_code, busy, digit_count
  );
endinterface

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Assembles ASCII frames START_CHAR, N_DIGITS decimal digits, END_CHAR from
// the UART receiver byte stream and emits a packed BCD code. Malformed,
// overlong or stalled frames are dropped and reported.
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    uart_frame_parser_if.slave (byte input, frame results)
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for START_CHAR, other bytes ignored
// DIGITS | collecting digits, fewer than N_DIGITS accepted so far
// TERM   | all digits in, waiting for END_CHAR ('\r' tolerated)
// ---------------------------------------------------------------------------
module uart_frame_parser #(
  parameter int         N_DIGITS       = 4,
  parameter logic [7:0] START_CHAR     = 8'h23,
  parameter logic [7:0] END_CHAR       = 8'h0A,
  parameter int         TIMEOUT_CYCLES = 520_833
) (
  input logic                clk,
  input logic                reset,
  uart_frame_parser_if.slave bus
);

  localparam int CW  = 4 * N_DIGITS;
  localparam int DCW = $clog2(N_DIGITS + 1);
  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // The counter is compared one step early so that the error pulse lands
  // TIMEOUT_CYCLES cycles after the last strobe, i.e. as the counter
  // reaches TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0]  TMO_TC     = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [DCW-1:0] LAST_DIGIT = DCW'(N_DIGITS - 1);
  localparam logic [7:0]     CR_CHAR    = 8'h0D;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERLONG = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    TERM   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] dig_buf;
  logic [TW-1:0] tmo_cnt;

  logic          is_digit;
  logic          is_start;
  logic          is_end;
  logic          is_cr;
  logic [3:0]    nibble;
  logic [CW-1:0] dig_next;

  always_comb begin
    is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    is_start = (bus.rx_data == START_CHAR);
    is_end   = (bus.rx_data == END_CHAR);
    is_cr    = (bus.rx_data == CR_CHAR);
    // For '0'..'9' the low nibble already equals rx_data - 8'h30.
    nibble   = bus.rx_data[3:0];
    // Shift form rather than a slice keeps N_DIGITS == 1 legal.
    dig_next = (dig_buf << 4) | CW'(nibble);
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      dig_buf         <= '0;
      tmo_cnt         <= '0;
      bus.code        <= '0;
      bus.digit_count <= '0;
      bus.error_code  <= ERR_NONE;
      bus.frame_valid <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.frame_error <= 1'b0;

      if (!bus.enable) begin
        state           <= IDLE;
        bus.digit_count <= '0;
        tmo_cnt         <= '0;
      end else if (bus.rx_valid) begin
        // A strobe always wins over a coincident terminal count.
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (is_start) begin
              dig_buf         <= '0;
              bus.digit_count <= '0;
              state           <= DIGITS;
            end
          end

          DIGITS: begin
            if (is_digit) begin
              dig_buf         <= dig_next;
              bus.digit_count <= bus.digit_count + 1'b1;
              if (bus.digit_count == LAST_DIGIT) begin
                state <= TERM;
              end
            end else if (is_start) begin
              dig_buf         <= '0;
              bus.digit_count <= '0;
            end else begin
              bus.frame_error <= 1'b1;
              bus.error_code  <= ERR_BAD_CHAR;
              bus.digit_count <= '0;
              state           <= IDLE;
            end
          end

          TERM: begin
            if (is_end) begin
              bus.code        <= dig_buf;
              bus.frame_valid <= 1'b1;
              bus.error_code  <= ERR_NONE;
              bus.digit_count <= '0;
              state           <= IDLE;
            end else if (is_cr) begin
              state <= TERM;
            end else if (is_digit) begin
              bus.frame_error <= 1'b1;
              bus.error_code  <= ERR_OVERLONG;
              bus.digit_count <= '0;
              state           <= IDLE;
            end else if (is_start) begin
              dig_buf         <= '0;
              bus.digit_count <= '0;
              state           <= DIGITS;
            end else begin
              bus.frame_error <= 1'b1;
              bus.error_code  <= ERR_BAD_CHAR;
              bus.digit_count <= '0;
              state           <= IDLE;
            end
          end

          default: begin
            bus.digit_count <= '0;
            state           <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO_TC) begin
          bus.frame_error <= 1'b1;
          bus.error_code  <= ERR_TIMEOUT;
          bus.digit_count <= '0;
          tmo_cnt         <= '0;
          state           <= IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int N   = 4;
  localparam int T   = 300;
  localparam int CW  = 4 * N;
  localparam int DCW = $clog2(N + 1);
  localparam logic [7:0] SC = 8'h23;
  localparam logic [7:0] EC = 8'h0A;

  logic clk;
  logic reset;

  uart_frame_parser_if #(.N_DIGITS(N)) bus ();

  uart_frame_parser #(
    .N_DIGITS      (N),
    .START_CHAR    (SC),
    .END_CHAR      (EC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a frame is "open" with a queue of digits collected so far.
  bit            m_active;
  int unsigned   m_q[$];
  int            m_idle;
  logic [CW-1:0] m_code;
  logic [1:0]    m_ec;
  bit            m_fv;
  bit            m_fe;

  int pulse_bad, track_bad, fv_seen, fe_seen, m_fv_cnt, m_fe_cnt;
  int cyc, strobe_cyc, fe_cyc;

  function automatic void model_reset();
    m_active = 0; m_q.delete(); m_idle = 0;
    m_code = '0; m_ec = 2'd0; m_fv = 0; m_fe = 0;
  endfunction

  function automatic void model_drop(input logic [1:0] e);
    m_fe = 1; m_ec = e; m_active = 0; m_q.delete(); m_idle = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] d, input bit en);
    bit dig;
    logic [CW-1:0] val;
    m_fv = 0; m_fe = 0;
    dig = (d >= "0") && (d <= "9");
    if (!en) begin
      m_active = 0; m_q.delete(); m_idle = 0;
      return;
    end
    if (v) begin
      m_idle = 0;
      if (d == SC) begin
        m_active = 1; m_q.delete();
      end else if (!m_active) begin
        // stray byte outside a frame
      end else if (m_q.size() < N) begin
        if (dig) m_q.push_back(int'(d) - 48);
        else model_drop(2'd1);
      end else if (d == EC) begin
        val = '0;
        foreach (m_q[i]) val = val * 16 + CW'(m_q[i]);
        m_code = val; m_fv = 1; m_ec = 2'd0;
        m_active = 0; m_q.delete();
      end else if (d == 8'h0D) begin
        // carriage return tolerated before the terminator
      end else if (dig) begin
        model_drop(2'd3);
      end else begin
        model_drop(2'd1);
      end
    end else if (m_active) begin
      m_idle++;
      if (m_idle == T - 1) model_drop(2'd2);
    end
  endfunction

  task automatic clear_stats();
    pulse_bad = 0; track_bad = 0; fv_seen = 0; fe_seen = 0;
    m_fv_cnt = 0; m_fe_cnt = 0; fe_cyc = -1;
  endtask

  // One clock: apply inputs, advance the model, record how the DUT compares.
  task automatic cycle(input bit v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = d;
    model_step(v, d, bus.enable);
    if (v) strobe_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (m_fv) m_fv_cnt++;
    if (m_fe) m_fe_cnt++;
    if (bus.frame_valid !== m_fv || bus.frame_error !== m_fe) pulse_bad++;
    if (bus.busy !== m_active || bus.digit_count !== DCW'(m_q.size()) ||
        bus.error_code !== m_ec || bus.code !== m_code) track_bad++;
    if (bus.frame_valid) fv_seen++;
    if (bus.frame_error) begin fe_seen++; fe_cyc = cyc; end
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      repeat ($urandom_range(0, maxgap)) cycle(1'b0, 8'h00);
      cycle(1'b1, s[i]);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.code !== '0) begin failures++; $display("FAIL reset_code got=%h want=0", bus.code); end
    checks++; if (bus.frame_valid !== 1'b0 || bus.frame_error !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b want=00", bus.frame_valid, bus.frame_error); end
    checks++; if (bus.error_code !== 2'd0 || bus.digit_count !== '0) begin failures++; $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.error_code, bus.digit_count); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.frame_valid !== 1'b0 || bus.frame_error !== 1'b0) begin failures++; $display("FAIL reset_release_pulse got=%b%b want=00", bus.frame_valid, bus.frame_error); end
  endtask

  task automatic test_valid_frame();
    clear_stats();
    send_str("#1234\n", 20);
    checks++; if (bus.frame_valid !== 1'b1) begin failures++; $display("FAIL valid_pulse got=%b want=1", bus.frame_valid); end
    checks++; if (bus.code !== 16'h1234) begin failures++; $display("FAIL valid_code got=%h want=1234", bus.code); end
    checks++; if (bus.error_code !== 2'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL valid_status got=ec%0d busy%b want=ec0 busy0", bus.error_code, bus.busy); end
    cycle(1'b0, 8'h00);
    checks++; if (fv_seen !== 1 || pulse_bad !== 0 || track_bad !== 0) begin failures++; $display("FAIL valid_trace got=fv%0d pb%0d tb%0d want=fv1 pb0 tb0", fv_seen, pulse_bad, track_bad); end
  endtask

  task automatic test_bad_char();
    clear_stats();
    send_str("#12a", 20);
    checks++; if (bus.frame_error !== 1'b1 || bus.error_code !== 2'd1) begin failures++; $display("FAIL badchar got=fe%b ec%0d want=fe1 ec1", bus.frame_error, bus.error_code); end
    checks++; if (bus.code !== 16'h1234 || bus.digit_count !== '0) begin failures++; $display("FAIL badchar_keep got=%h dc%0d want=1234 dc0", bus.code, bus.digit_count); end
    cycle(1'b0, 8'h00);
    checks++; if (pulse_bad !== 0 || track_bad !== 0) begin failures++; $display("FAIL badchar_trace got=pb%0d tb%0d want=0 0", pulse_bad, track_bad); end
  endtask

  task automatic test_overlong();
    clear_stats();
    send_str("#9876", 20);
    checks++; if (bus.busy !== 1'b1 || bus.digit_count !== DCW'(N)) begin failures++; $display("FAIL full_count got=busy%b dc%0d want=busy1 dc%0d", bus.busy, bus.digit_count, N); end
    send_str("5", 20);
    checks++; if (bus.frame_error !== 1'b1 || bus.error_code !== 2'd3) begin failures++; $display("FAIL overlong got=fe%b ec%0d want=fe1 ec3", bus.frame_error, bus.error_code); end
    send_str("\n#4321\r\n", 20);
    checks++; if (bus.frame_valid !== 1'b1 || bus.code !== 16'h4321 || bus.error_code !== 2'd0) begin failures++; $display("FAIL cr_frame got=fv%b %h ec%0d want=fv1 4321 ec0", bus.frame_valid, bus.code, bus.error_code); end
    checks++; if (pulse_bad !== 0 || track_bad !== 0 || fe_seen !== 1) begin failures++; $display("FAIL overlong_trace got=pb%0d tb%0d fe%0d want=0 0 1", pulse_bad, track_bad, fe_seen); end
  endtask

  task automatic test_restart();
    clear_stats();
    send_str("#12#5678\n", 20);
    checks++; if (bus.code !== 16'h5678 || fv_seen !== 1 || fe_seen !== 0) begin failures++; $display("FAIL restart got=%h fv%0d fe%0d want=5678 fv1 fe0", bus.code, fv_seen, fe_seen); end
    send_str("#1234#", 20);
    send_str("9999\n", 20);
    checks++; if (bus.code !== 16'h9999 || pulse_bad !== 0 || track_bad !== 0) begin failures++; $display("FAIL restart_term got=%h pb%0d tb%0d want=9999 0 0", bus.code, pulse_bad, track_bad); end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    send_str("#8765\n#0246\n", 0);
    checks++; if (bus.code !== 16'h0246 || fv_seen !== 2 || pulse_bad !== 0 || track_bad !== 0) begin failures++; $display("FAIL b2b got=%h fv%0d pb%0d tb%0d want=0246 fv2 0 0", bus.code, fv_seen, pulse_bad, track_bad); end
  endtask

  task automatic test_timeout();
    clear_stats();
    send_str("#12", 10);
    repeat (T + 5) cycle(1'b0, 8'h00);
    checks++; if (fe_seen !== 1 || fe_cyc - strobe_cyc !== T) begin failures++; $display("FAIL timeout_latency got=n%0d lat%0d want=n1 lat%0d", fe_seen, fe_cyc - strobe_cyc, T); end
    checks++; if (bus.error_code !== 2'd2 || bus.busy !== 1'b0 || pulse_bad !== 0) begin failures++; $display("FAIL timeout_status got=ec%0d busy%b pb%0d want=ec2 busy0 pb0", bus.error_code, bus.busy, pulse_bad); end
    clear_stats();
    send_str("#12", 10);
    repeat (T - 2) cycle(1'b0, 8'h00);
    cycle(1'b1, "3");
    checks++; if (fe_seen !== 0 || bus.busy !== 1'b1 || bus.digit_count !== DCW'(3)) begin failures++; $display("FAIL timeout_tc_strobe got=fe%0d busy%b dc%0d want=fe0 busy1 dc3", fe_seen, bus.busy, bus.digit_count); end
    send_str("4\n", 10);
    checks++; if (bus.code !== 16'h1234 || fv_seen !== 1 || track_bad !== 0) begin failures++; $display("FAIL timeout_recover got=%h fv%0d tb%0d want=1234 fv1 tb0", bus.code, fv_seen, track_bad); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    send_str("#12", 10);
    cycle(1'b0, 8'h00);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.digit_count !== '0 || bus.code !== '0 || bus.error_code !== 2'd0) begin failures++; $display("FAIL reset_mid got=busy%b dc%0d %h ec%0d want=all zero", bus.busy, bus.digit_count, bus.code, bus.error_code); end
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    send_str("34\n", 10);
    repeat (3) cycle(1'b0, 8'h00);
    checks++; if (fv_seen !== 0 || fe_seen !== 0 || bus.code !== '0 || track_bad !== 0) begin failures++; $display("FAIL reset_after got=fv%0d fe%0d %h tb%0d want=0 0 0000 0", fv_seen, fe_seen, bus.code, track_bad); end
  endtask

  task automatic test_enable();
    clear_stats();
    send_str("#9012\n", 10);
    send_str("#56", 10);
    bus.enable = 1'b0;
    cycle(1'b0, 8'h00);
    checks++; if (bus.busy !== 1'b0 || bus.digit_count !== '0) begin failures++; $display("FAIL enable_drop got=busy%b dc%0d want=busy0 dc0", bus.busy, bus.digit_count); end
    send_str("78\n#1111\n", 5);
    checks++; if (fv_seen !== 1 || fe_seen !== 0 || bus.code !== 16'h9012 || bus.busy !== 1'b0) begin failures++; $display("FAIL enable_ignore got=fv%0d fe%0d %h busy%b want=1 0 9012 0", fv_seen, fe_seen, bus.code, bus.busy); end
    bus.enable = 1'b1;
    send_str("#3456\n", 10);
    checks++; if (bus.code !== 16'h3456 || pulse_bad !== 0 || track_bad !== 0) begin failures++; $display("FAIL enable_resume got=%h pb%0d tb%0d want=3456 0 0", bus.code, pulse_bad, track_bad); end
  endtask

  task automatic test_random();
    logic [7:0] pool [0:13];
    pool = '{"0", "1", "2", "3", "4", "5", "6", "7", "8", "9", SC, EC, 8'h0D, "x"};
    clear_stats();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 40) == 0) repeat (T + 2) cycle(1'b0, 8'h00);
      else repeat ($urandom_range(0, 6)) cycle(1'b0, 8'h00);
      if ($urandom_range(0, 3) == 0) cycle(1'b1, pool[$urandom_range(10, 13)]);
      else cycle(1'b1, pool[$urandom_range(0, 9)]);
    end
    checks++; if (pulse_bad !== 0) begin failures++; $display("FAIL random_pulses got=%0d bad cycles want=0", pulse_bad); end
    checks++; if (track_bad !== 0) begin failures++; $display("FAIL random_outputs got=%0d bad cycles want=0", track_bad); end
    checks++; if (fv_seen !== m_fv_cnt || fe_seen !== m_fe_cnt) begin failures++; $display("FAIL random_counts got=fv%0d fe%0d want=fv%0d fe%0d", fv_seen, fe_seen, m_fv_cnt, m_fe_cnt); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.enable   = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    cyc = 0; strobe_cyc = 0;
    model_reset();
    clear_stats();
    test_reset();
    test_valid_frame();
    test_bad_char();
    test_overlong();
    test_restart();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
